// File: rtl/serial_addsub_nibble.sv
// serial_addsub_nibble: WIDTH-bit adder/subtractor that walks the operands one
// nibble per clock (LSB nibble first) through a single 4-bit carry-look-ahead
// slice, keeping the inter-nibble carry in a register.
//
// Optional feature: define SERIAL_ADDSUB_ZERO_FLAG_EN to add the `z` output
// (result-is-zero flag built from a sticky OR of every nibble sum).

// 4-bit carry-look-ahead add/sub slice. With sub=1 the y operand is inverted
// and the carry-in forced to 1 (two's complement subtract).
module claAddSub4 (
    input  logic       sub,
    input  logic       cin,
    input  logic [3:0] x,
    input  logic [3:0] y,
    output logic [3:0] sum,
    output logic       cout,
    output logic       v
);

    logic [3:0] yy;
    logic [3:0] g;
    logic [3:0] p;
    logic [4:0] c;

    // Generate/propagate terms and flat look-ahead carries for all four bits.
    always_comb begin
        yy   = y ^ {4{sub}};
        g    = x & yy;
        p    = x ^ yy;
        c[0] = cin | sub;
        c[1] = g[0] | (p[0] & c[0]);
        c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & c[0]);
        c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0])
             | (p[2] & p[1] & p[0] & c[0]);
        c[4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1])
             | (p[3] & p[2] & p[1] & g[0])
             | (p[3] & p[2] & p[1] & p[0] & c[0]);
        sum  = p ^ c[3:0];
        cout = c[4];
        v    = c[3] ^ c[4];
    end

endmodule

module serial_addsub_nibble #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             sub,
    input  logic             cin,
    input  logic [WIDTH-1:0] x,
    input  logic [WIDTH-1:0] y,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out,
    output logic             cout,
`ifdef SERIAL_ADDSUB_ZERO_FLAG_EN
    output logic             v,
    output logic             z
`else
    output logic             v
`endif
);

    localparam int N  = WIDTH / 4;
    localparam int KW = (N > 1) ? $clog2(N) : 1;
    localparam logic [KW-1:0] LAST_K = KW'(N - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t state;
    state_t state_n;

    // Operands are shifted right one nibble per RUN cycle so the slice
    // always reads bits [3:0]; the result fills from the top so that after
    // N cycles nibble 0 sits at the bottom.
    logic [WIDTH-1:0] x_sh;
    logic [WIDTH-1:0] y_sh;
    logic             sub_lat;
    logic             carry;
    logic [KW-1:0]    k;
    logic [WIDTH-1:0] result;
    logic             cout_r;
    logic             v_r;

    logic             accept;
    logic             last;
    logic [3:0]       y_nib;
    logic [3:0]       slice_sum;
    logic             slice_cout;
    logic             slice_v;
    logic [WIDTH-1:0] sum_top;

    assign accept  = in_valid && (state == IDLE);
    assign last    = (state == RUN) && (k == LAST_K);
    assign y_nib   = y_sh[3:0] ^ {4{sub_lat}};
    assign sum_top = WIDTH'(slice_sum) << (WIDTH - 4);

    claAddSub4 u_slice (
        .sub  (1'b0),
        .cin  (carry),
        .x    (x_sh[3:0]),
        .y    (y_nib),
        .sum  (slice_sum),
        .cout (slice_cout),
        .v    (slice_v)
    );

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_n;
        end
    end

    // Next-state logic and handshake outputs decoded from the state register.
    always_comb begin
        state_n   = state;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        case (state)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    state_n = RUN;
                end
            end
            RUN: begin
                if (k == LAST_K) begin
                    state_n = DONE;
                end
            end
            DONE: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    state_n = IDLE;
                end
            end
            default: begin
                state_n = IDLE;
            end
        endcase
    end

    // Operand capture on accept, then one nibble per RUN cycle; final
    // carry and overflow are latched on the last nibble.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            x_sh    <= '0;
            y_sh    <= '0;
            sub_lat <= 1'b0;
            carry   <= 1'b0;
            k       <= '0;
            result  <= '0;
            cout_r  <= 1'b0;
            v_r     <= 1'b0;
        end else if (accept) begin
            x_sh    <= x;
            y_sh    <= y;
            sub_lat <= sub;
            carry   <= sub | cin;
            k       <= '0;
        end else if (state == RUN) begin
            x_sh   <= x_sh >> 4;
            y_sh   <= y_sh >> 4;
            result <= (result >> 4) | sum_top;
            carry  <= slice_cout;
            k      <= k + KW'(1);
            if (last) begin
                cout_r <= slice_cout;
                v_r    <= slice_v;
            end
        end
    end

    assign out  = result;
    assign cout = cout_r;
    assign v    = v_r;

`ifdef SERIAL_ADDSUB_ZERO_FLAG_EN
    logic sticky;
    logic z_r;

    // Sticky OR of all nibble sums; z is its inverse, captured on the last nibble.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sticky <= 1'b0;
            z_r    <= 1'b0;
        end else if (accept) begin
            sticky <= 1'b0;
        end else if (state == RUN) begin
            sticky <= sticky | (|slice_sum);
            if (last) begin
                z_r <= ~(sticky | (|slice_sum));
            end
        end
    end

    assign z = z_r;
`endif

endmodule

// File: tb/tb_serial_addsub_nibble.sv
// Directed-vector bench for serial_addsub_nibble (WIDTH=32 and WIDTH=4 instances).
`timescale 1ns/1ps

module tb_serial_addsub_nibble;

    logic        clk = 1'b0;
    logic        rst = 1'b1;

    logic        in_valid  = 1'b0;
    logic        in_ready;
    logic        sub       = 1'b0;
    logic        cin       = 1'b0;
    logic [31:0] x         = '0;
    logic [31:0] y         = '0;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [31:0] out;
    logic        cout;
    logic        v;

    logic        in_valid4  = 1'b0;
    logic        in_ready4;
    logic        sub4       = 1'b0;
    logic        cin4       = 1'b0;
    logic [3:0]  x4         = '0;
    logic [3:0]  y4         = '0;
    logic        out_valid4;
    logic        out_ready4 = 1'b1;
    logic [3:0]  out4;
    logic        cout4;
    logic        v4;

`ifdef SERIAL_ADDSUB_ZERO_FLAG_EN
    logic        z;
    logic        z4;
`endif

    int tests_run    = 0;
    int tests_failed = 0;

    always #5 clk = ~clk;

    serial_addsub_nibble #(.WIDTH(32)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .sub       (sub),
        .cin       (cin),
        .x         (x),
        .y         (y),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out       (out),
        .cout      (cout),
`ifdef SERIAL_ADDSUB_ZERO_FLAG_EN
        .v         (v),
        .z         (z)
`else
        .v         (v)
`endif
    );

    serial_addsub_nibble #(.WIDTH(4)) dut4 (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid4),
        .in_ready  (in_ready4),
        .sub       (sub4),
        .cin       (cin4),
        .x         (x4),
        .y         (y4),
        .out_valid (out_valid4),
        .out_ready (out_ready4),
        .out       (out4),
        .cout      (cout4),
`ifdef SERIAL_ADDSUB_ZERO_FLAG_EN
        .v         (v4),
        .z         (z4)
`else
        .v         (v4)
`endif
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Wait (bounded) for in_ready on the 32-bit instance, then present operands for one edge.
    task automatic accept32(input string tag, input logic s, input logic c,
                            input logic [31:0] a, input logic [31:0] b);
        int guard = 0;
        while (!in_ready && guard < 40) begin
            @(posedge clk); #1;
            guard++;
        end
        check({tag, "_ready_to"}, 64'(guard < 40), 64'd1);
        in_valid = 1'b1;
        sub      = s;
        cin      = c;
        x        = a;
        y        = b;
        @(posedge clk); #1;
        in_valid = 1'b0;
        x        = 32'hDEAD_BEEF;
        y        = 32'h1234_5678;
        sub      = ~s;
        cin      = ~c;
    endtask

    // Count edges from the accepting edge until out_valid is seen.
    task automatic wait_done32(output int lat);
        lat = 0;
        while (!out_valid && lat < 20) begin
            @(posedge clk); #1;
            lat++;
            if (!out_valid) check("run_in_ready", 64'(in_ready), 64'd0);
        end
    endtask

    // One full operation with out_ready held high.
    task automatic op32(input string tag, input logic s, input logic c,
                        input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] eo, input logic ec, input logic ev);
        int lat;
        accept32(tag, s, c, a, b);
        wait_done32(lat);
        check({tag, "_lat"},  64'(lat),  64'd8);
        check({tag, "_out"},  64'(out),  64'(eo));
        check({tag, "_cout"}, 64'(cout), 64'(ec));
        check({tag, "_v"},    64'(v),    64'(ev));
`ifdef SERIAL_ADDSUB_ZERO_FLAG_EN
        check({tag, "_z"},    64'(z),    64'(eo == 32'd0));
`endif
        @(posedge clk); #1;
        check({tag, "_ov_drop"}, 64'(out_valid), 64'd0);
        check({tag, "_rdy_back"}, 64'(in_ready), 64'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int lat;
        logic [31:0] held;

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        check("rst_in_ready",  64'(in_ready),  64'd1);
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_out",       64'(out),       64'd0);
        check("rst_cout",      64'(cout),      64'd0);
        check("rst_v",         64'(v),         64'd0);
        rst = 1'b0;

        // Carry ripples through every nibble
        op32("add_wrap", 1'b0, 1'b0, 32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0000, 1'b1, 1'b0);
        // Signed overflow cases
        op32("sub_ovf",  1'b1, 1'b0, 32'h8000_0000, 32'h0000_0001, 32'h7FFF_FFFF, 1'b1, 1'b1);
        op32("add_ovf",  1'b0, 1'b0, 32'h7FFF_FFFF, 32'h0000_0001, 32'h8000_0000, 1'b0, 1'b1);
        // cin ignored in subtract, honoured in add
        op32("sub_cin",  1'b1, 1'b1, 32'h0000_0005, 32'h0000_0005, 32'h0000_0000, 1'b1, 1'b0);
        op32("add_cin",  1'b0, 1'b1, 32'h0000_0005, 32'h0000_0005, 32'h0000_000B, 1'b0, 1'b0);

        // Backpressure in DONE with a new in_valid pulse
        out_ready = 1'b0;
        accept32("bp", 1'b0, 1'b0, 32'h1234_5678, 32'h1111_1111);
        wait_done32(lat);
        check("bp_lat", 64'(lat), 64'd8);
        check("bp_out", 64'(out), 64'h2345_6789);
        held = out;
        for (int i = 0; i < 3; i++) begin
            in_valid = 1'b1;
            x        = 32'hFFFF_FFFF;
            y        = 32'h0000_0001;
            @(posedge clk); #1;
            check("bp_hold_out",   64'(out),       64'(held));
            check("bp_hold_valid", 64'(out_valid), 64'd1);
            check("bp_hold_ready", 64'(in_ready),  64'd0);
            check("bp_hold_cout",  64'(cout),      64'd0);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(posedge clk); #1;
        check("bp_release_valid", 64'(out_valid), 64'd0);
        check("bp_release_ready", 64'(in_ready),  64'd1);
        check("bp_release_out",   64'(out),       64'h2345_6789);

        // Asynchronous reset in the middle of RUN (k=3)
        accept32("mid", 1'b1, 1'b0, 32'hAAAA_AAAA, 32'h1111_1111);
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b1;
        #1;
        check("mid_rst_valid", 64'(out_valid), 64'd0);
        check("mid_rst_ready", 64'(in_ready),  64'd1);
        check("mid_rst_out",   64'(out),       64'd0);
        check("mid_rst_cout",  64'(cout),      64'd0);
        #2;
        rst = 1'b0;
        op32("after_rst", 1'b1, 1'b0, 32'h0000_0003, 32'h0000_0007, 32'hFFFF_FFFC, 1'b0, 1'b0);

        // WIDTH=4 instance: single RUN cycle
        in_valid4 = 1'b1;
        x4        = 4'h7;
        y4        = 4'h1;
        @(posedge clk); #1;
        in_valid4 = 1'b0;
        x4        = 4'hF;
        lat = 0;
        while (!out_valid4 && lat < 10) begin
            @(posedge clk); #1;
            lat++;
        end
        check("w4_lat",  64'(lat),   64'd1);
        check("w4_out",  64'(out4),  64'h8);
        check("w4_v",    64'(v4),    64'd1);
        check("w4_cout", 64'(cout4), 64'd0);
`ifdef SERIAL_ADDSUB_ZERO_FLAG_EN
        check("w4_z",    64'(z4),    64'd0);
`endif
        @(posedge clk); #1;
        check("w4_ready_back", 64'(in_ready4), 64'd1);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/serial_addsub_nibble.md
# serial_addsub_nibble

- Multi-cycle N-bit adder-subtractor that processes one 4-bit nibble per clock, LSB nibble first.
- Uses a single 4-bit carry-look-ahead add/sub slice (`claAddSub4`) plus a registered inter-nibble carry.
- Sits in front of the ALU result path as the area-optimised alternative to a full-width CLA tree.
- Accepts operands over a valid/ready handshake and holds the result until consumed.

## Interface
Parameters:
- `WIDTH`, default 32: operand width in bits. Must be a multiple of 4 and ≥ 4. Nibble count N = WIDTH/4.

Ports:
- `clk` input, 1 bit: single clock; all state updates on the rising edge.
- `rst` input, 1 bit: asynchronous, active-high reset.
- `in_valid` input, 1 bit: operands valid.
- `in_ready` output, 1 bit: block can accept operands.
- `sub` input, 1 bit: 1 = x − y, 0 = x + y.
- `cin` input, 1 bit: carry-in for add. Ignored when `sub`=1.
- `x` input, WIDTH bits: operand A.
- `y` input, WIDTH bits: operand B.
- `out_valid` output, 1 bit: result valid.
- `out_ready` input, 1 bit: consumer accepts result.
- `out` output, WIDTH bits: sum/difference modulo 2^WIDTH.
- `cout` output, 1 bit: carry out of the MSB. For subtract, 1 = no borrow.
- `v` output, 1 bit: signed overflow.
- `z` output, 1 bit: `out` is all zero. Present only with `SERIAL_ADDSUB_ZERO_FLAG_EN`.

## Operation
FSM states: IDLE, RUN, DONE. Reset state is IDLE.

IDLE
- `in_ready`=1, `out_valid`=0.
- On `in_valid`&`in_ready`:
  - latch x, y and `sub`;
  - carry register ← `sub` | `cin`;
  - nibble index k ← 0;
  - go to RUN.

RUN
- `in_ready`=0, `out_valid`=0. Each cycle processes nibble k.
- Slice inputs:
  - `sub` tied 0;
  - `x` = x[4k+3:4k];
  - `y` = y[4k+3:4k] ^ {4{sub_latched}};
  - `cin` = carry register.
- Register updates each RUN cycle:
  - result[4k+3:4k] ← slice sum;
  - carry register ← slice cout;
  - k ← k+1.
- On k = N−1:
  - `cout` ← slice cout;
  - `v` ← slice v (carry into nibble bit 3 XOR carry out);
  - go to DONE.
- The index counter is max(1, $clog2(N)) bits wide. It is never compared beyond N−1.

DONE
- `out_valid`=1, `in_ready`=0.
- `out`, `cout`, `v` (and `z`) are held stable.
- On `out_ready`=1: go to IDLE.

General rules
- Inputs `x`, `y`, `sub`, `cin` are sampled only at the accepting edge. Later changes to them have no effect.
- `in_valid` during RUN or DONE is ignored; no queuing.

Reset values (also on reset mid-operation)
- State = IDLE.
- `out`=0, `cout`=0, `v`=0, `z`=0, `out_valid`=0, `in_ready`=1.
- Any partially computed result is discarded.

## Timing
- Accept handshake at edge t: RUN covers edges t+1 … t+N, and `out_valid` rises after edge t+N. Latency = N cycles (8 for WIDTH=32).
- With `out_ready` held 1: `out_valid` is high for exactly one cycle, IDLE is re-entered at edge t+N+1, and `in_ready` is high again in the cycle after that.
- Throughput is one operation per N+2 cycles.
- WIDTH=4: a single RUN cycle, latency 1.
- Outputs are registered. There is no combinational path from `x`/`y` to any output, nor from `out_ready` to `in_ready`.
- `rst` asserted at any point forces the reset values immediately (asynchronously). The first acceptance is possible at the first clock edge after `rst` deasserts.

## Configuration
Macro `SERIAL_ADDSUB_ZERO_FLAG_EN`.

Defined:
- Port `z` exists.
- A sticky register is cleared on accept and ORs in each nibble's sum during RUN.
- `z` = NOT(sticky), registered on the DONE transition and held through DONE.

Undefined:
- No `z` port and no sticky register.
- All other behaviour is identical.

## Test plan
1. WIDTH=32, add 0xFFFFFFFF + 0x00000001, cin=0 → `out`=0x00000000, `cout`=1, `v`=0, `z`=1; `out_valid` rises exactly 8 cycles after accept.
2. Subtract 0x80000000 − 0x00000001 → `out`=0x7FFFFFFF, `cout`=1, `v`=1. Add 0x7FFFFFFF + 0x00000001 → `out`=0x80000000, `cout`=0, `v`=1.
3. Subtract 5 − 5 with cin=1 (must be ignored) → `out`=0, `cout`=1, `v`=0. Add 5 + 5 with cin=1 → `out`=0x0000000B.
4. Backpressure: hold `out_ready`=0 for 3 cycles in DONE and pulse `in_valid` with new operands → outputs stable, `in_ready`=0, new operands not taken. Raise `out_ready` → IDLE on the next edge.
5. Assert `rst` during RUN at k=3 → immediately `out_valid`=0, `in_ready`=1, `out`=0. A subsequent operation 3 − 7 completes correctly: `out`=0xFFFFFFFC, `cout`=0.
6. WIDTH=4 instance, add 0x7 + 0x1 → `out`=0x8, `v`=1, `cout`=0, latency 1 cycle.
